// File: rtl/mem_pkg.sv
// Shared size codes, FSM encoding and the misalignment test for the MEM-stage access unit.
package mem_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // mode[1] set means word, otherwise mode[0] selects half over byte.
  function automatic logic misaligned(input logic [2:0] mode, input logic [1:0] a);
    if (mode[1]) return (a != 2'b00);
    else if (mode[0]) return a[0];
    else return 1'b0;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store strobes/replication and load lane extract with extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  a,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    byte_sh = rdata >> {a, 3'b000};
    half_sh = rdata >> {a[1], 4'b0000};
    wstrb   = 4'b1111;
    wdata   = sdata;
    ld      = rdata;
    if (mode[1]) begin
      wstrb = 4'b1111;
    end else if (mode[0]) begin
      // Half accesses ignore a[0]: misaligned halves are aligned down.
      wstrb = 4'b0011 << {a[1], 1'b0};
      wdata = {2{sdata[15:0]}};
      ld    = mode[2] ? {16'h0000, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
    end else begin
      wstrb = 4'b0001 << a;
      wdata = {4{sdata[7:0]}};
      ld    = mode[2] ? {24'h000000, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one handshaked word-bus transaction per load/store.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses retire with bus_err instead of going to the bus.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [2:0]        dm_mode,
  input  logic              dmrd,
  input  logic              dmwe,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_data,
  output logic [31:0]       ld_data,
  output logic              done,
  output logic              stall,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t            state;
  state_t            next;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [2:0]        mode_q;
  logic              we_q;
  logic [31:0]       ld_q;
  logic              err_q;
  logic              clr_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              start;
  logic              trap;
  logic              timeout;
  logic [3:0]        lane_wstrb;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_ld;

  // rst gates start so stall stays low while reset is held.
  assign start = (dmrd | dmwe) & ~clear & ~rst;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = misaligned(dm_mode, dm_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign timeout = (MAX_WAIT > 0) && (wait_cnt == CNT_W'(MAX_WAIT - 1));

  mem_lane_align u_lane (
    .mode  (mode_q),
    .a     (addr_q[1:0]),
    .sdata (data_q),
    .rdata (bus_rdata),
    .wstrb (lane_wstrb),
    .wdata (lane_wdata),
    .ld    (lane_ld)
  );

  always_comb begin
    next      = state;
    stall     = 1'b0;
    done      = 1'b0;
    ld_data   = 32'h0;
    bus_err   = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = 32'h0;
    bus_wstrb = 4'h0;
    case (state)
      IDLE: begin
        if (start) begin
          stall = 1'b1;
          next  = trap ? DONE : BUS;
        end
      end
      BUS: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus_wdata = we_q ? lane_wdata : 32'h0;
        bus_wstrb = we_q ? lane_wstrb : 4'h0;
        if (bus_ack || timeout) next = DONE;
      end
      DONE: begin
        done    = 1'b1;
        ld_data = ld_q;
        bus_err = err_q;
        next    = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= 32'h0;
      mode_q   <= 3'b000;
      we_q     <= 1'b0;
      ld_q     <= 32'h0;
      err_q    <= 1'b0;
      clr_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= next;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q   <= dm_addr;
            data_q   <= dm_data;
            mode_q   <= dm_mode;
            we_q     <= dmwe;
            ld_q     <= 32'h0;
            err_q    <= trap;
            clr_q    <= 1'b0;
            wait_cnt <= '0;
          end
        end
        BUS: begin
          // A flush here cannot abandon the handshake; it only blanks the reported result.
          if (clear) clr_q <= 1'b1;
          if (bus_ack) begin
            ld_q     <= (we_q | clr_q | clear) ? 32'h0 : lane_ld;
            err_q    <= 1'b0;
            wait_cnt <= '0;
          end else if (timeout) begin
            ld_q     <= 32'h0;
            err_q    <= ~(clr_q | clear);
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; a second instance with MAX_WAIT=4 covers the timeout.
module tb_mem_access_unit;
  import mem_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [2:0]  dm_mode = 3'b000;
  logic        dmrd = 1'b0;
  logic        dmwe = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_data = 32'h0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic        ack_to = 1'b0;

  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic        done, stall, bus_err, bus_req, bus_we;
  logic [3:0]  bus_wstrb;

  logic [31:0] ld_data_to, bus_addr_to, bus_wdata_to;
  logic        done_to, stall_to, bus_err_to, bus_req_to, bus_we_to;
  logic [3:0]  bus_wstrb_to;

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  mem_access_unit #(.ADDR_W(32), .MAX_WAIT(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .dm_mode(dm_mode), .dmrd(dmrd), .dmwe(dmwe),
    .dm_addr(dm_addr), .dm_data(dm_data), .ld_data(ld_data), .done(done), .stall(stall),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  mem_access_unit #(.ADDR_W(32), .MAX_WAIT(4)) dut_to (
    .clk(clk), .rst(rst), .clear(clear), .dm_mode(dm_mode), .dmrd(dmrd), .dmwe(dmwe),
    .dm_addr(dm_addr), .dm_data(dm_data), .ld_data(ld_data_to), .done(done_to), .stall(stall_to),
    .bus_err(bus_err_to), .bus_req(bus_req_to), .bus_we(bus_we_to), .bus_addr(bus_addr_to),
    .bus_wdata(bus_wdata_to), .bus_wstrb(bus_wstrb_to), .bus_rdata(bus_rdata), .bus_ack(ack_to)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_strb(input logic [2:0] mode, input logic [1:0] a);
    case (mode)
      DM_B, DM_BU: return 4'b0001 << a;
      DM_H, DM_HU: return a[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] mode, input logic [31:0] d);
    case (mode)
      DM_B, DM_BU: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      DM_H, DM_HU: return {d[15:0], d[15:0]};
      default:     return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] mode, input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (mode)
      DM_B:    return {{24{b[7]}}, b};
      DM_BU:   return {24'h0, b};
      DM_H:    return {{16{h[15]}}, h};
      DM_HU:   return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  task automatic do_reset();
    dmrd = 1'b0; dmwe = 1'b0; clear = 1'b0; bus_ack = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
  task automatic run_access(input string name, input logic we, input logic both, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                            input int dly, input logic clr_in_bus);
    int    n_req, n_stall, cyc;
    logic  mis, trap_it;
    logic [31:0] exp_ld;
    mis     = ((mode == DM_H || mode == DM_HU) && addr[0]) || (mode == DM_W && addr[1:0] != 2'b00);
    trap_it = TRAP && mis;
    exp_ld  = (we || clr_in_bus || trap_it) ? 32'h0 : m_load(mode, addr[1:0], rd);
    exp_q.push_back({trap_it, exp_ld});
    dmrd = ~we | both; dmwe = we; dm_mode = mode; dm_addr = addr; dm_data = wd;
    n_req = 0; n_stall = 0;
    for (cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (done) break;
      if (stall) n_stall++;
      if (bus_req) begin
        n_req++;
        check_eq({name, " addr"}, bus_addr, {addr[31:2], 2'b00});
        if (n_req == 1) begin
          check_eq({name, " we"}, bus_we, we);
          check_eq({name, " wstrb"}, bus_wstrb, we ? m_strb(mode, addr[1:0]) : 4'h0);
          if (we) check_eq({name, " wdata"}, bus_wdata, m_wdata(mode, wd));
          clear = clr_in_bus;
        end
        if (n_req > dly) begin
          bus_ack = 1'b1; bus_rdata = rd;
        end else begin
          bus_rdata = $urandom;
        end
      end
      @(posedge clk);
      #1;
      dmrd = 1'b0; dmwe = 1'b0; bus_ack = 1'b0; clear = 1'b0; bus_rdata = $urandom;
      dm_addr = $urandom; dm_data = $urandom;
    end
    check_eq({name, " done"}, done, 1'b1);
    if (exp_q.size() > 0) check_eq({name, " err/ld"}, {bus_err, ld_data}, exp_q.pop_front());
    check_eq({name, " stall in done"}, stall, 1'b0);
    check_eq({name, " req cycles"}, n_req, trap_it ? 0 : dly + 1);
    check_eq({name, " stall cycles"}, n_stall, trap_it ? 1 : dly + 2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_req, n_stall;
    logic [2:0] lmodes[5];
    logic [2:0] smodes[3];
    lmodes = '{DM_B, DM_H, DM_W, DM_BU, DM_HU};
    smodes = '{DM_B, DM_H, DM_W};

    do_reset();
    check_eq("rst ld_data", ld_data, 0);
    check_eq("rst done", done, 0);
    check_eq("rst stall", stall, 0);
    check_eq("rst bus_err", bus_err, 0);
    check_eq("rst bus_req", bus_req, 0);
    check_eq("rst bus_we", bus_we, 0);
    check_eq("rst bus_addr", bus_addr, 0);
    check_eq("rst bus_wdata", bus_wdata, 0);
    check_eq("rst bus_wstrb", bus_wstrb, 0);

    repeat (3) begin
      #1 check_eq("idle no stall", stall, 0);
      @(posedge clk); #1;
    end

    run_access("sw", 1, 0, DM_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    run_access("sb", 1, 0, DM_B, 32'h103, 32'h0000005A, 32'h0, 0, 0);
    run_access("sh", 1, 0, DM_H, 32'h102, 32'h00001234, 32'h0, 1, 0);
    run_access("lb", 0, 0, DM_B, 32'h101, 32'h0, 32'h00008000, 0, 0);
    run_access("lbu", 0, 0, DM_BU, 32'h101, 32'h0, 32'h00008000, 0, 0);
    run_access("lh", 0, 0, DM_H, 32'h102, 32'h0, 32'h80010000, 2, 0);
    run_access("lhu", 0, 0, DM_HU, 32'h100, 32'h0, 32'h0000F00D, 0, 0);
    run_access("lw dly5", 0, 0, DM_W, 32'h204, 32'h0, 32'hCAFEF00D, 5, 0);
    run_access("rd+wr", 1, 1, DM_W, 32'h300, 32'h11223344, 32'h55667788, 0, 0);
    run_access("clear bus", 0, 0, DM_W, 32'h400, 32'h0, 32'h12345678, 2, 1);
    run_access("lw mis", 0, 0, DM_W, 32'h102, 32'h0, 32'h87654321, 0, 0);
    run_access("lh mis", 0, 0, DM_H, 32'h103, 32'h0, 32'h80017FFF, 0, 0);

    // clear in IDLE blocks the start of an access
    dmrd = 1'b1; dm_mode = DM_W; dm_addr = 32'h500; clear = 1'b1;
    #1 check_eq("clear idle stall", stall, 0);
    @(posedge clk); #1;
    dmrd = 1'b0; clear = 1'b0;
    #1 check_eq("clear idle no req", bus_req, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      logic        we;
      logic [2:0]  mode;
      logic [31:0] a;
      we   = $urandom_range(0, 1);
      mode = we ? smodes[$urandom_range(0, 2)] : lmodes[$urandom_range(0, 4)];
      a    = $urandom;
      if (mode == DM_H || mode == DM_HU) a[0] = 1'b0;
      if (mode == DM_W) a[1:0] = 2'b00;
      run_access("rand", we, 0, mode, a, $urandom, $urandom, $urandom_range(0, 3), 0);
    end

    // Timeout on the MAX_WAIT=4 instance; the MAX_WAIT=0 instance keeps waiting.
    do_reset();
    exp_q.push_back({1'b1, 32'h0});
    dmrd = 1'b1; dm_mode = DM_W; dm_addr = 32'h600;
    n_req = 0; n_stall = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (done_to) break;
      if (bus_req_to) n_req++;
      if (stall_to) n_stall++;
      @(posedge clk); #1;
      dmrd = 1'b0;
    end
    check_eq("to done", done_to, 1'b1);
    if (exp_q.size() > 0) check_eq("to err/ld", {bus_err_to, ld_data_to}, exp_q.pop_front());
    check_eq("to req cycles", n_req, 4);
    check_eq("to stall cycles", n_stall, 5);
    check_eq("wait forever req", bus_req, 1'b1);
    @(posedge clk); #1;
    check_eq("to err pulse", bus_err_to, 1'b0);

    // Asynchronous reset while in BUS
    rst = 1'b1;
    #1;
    check_eq("rst mid req", bus_req, 0);
    check_eq("rst mid stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dmrd = 1'b1; dm_mode = DM_W; dm_addr = 32'h700;
    @(posedge clk); #1;
    dmrd = 1'b0;
    check_eq("pre-rst req", bus_req, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst bus req", bus_req, 0);
    check_eq("rst bus stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check_eq("after rst done", done, 0);
    @(posedge clk); #1;

    check_eq("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
